// File: rtl/arc4_pkg.sv
// Shared types and default widths for the ARC4 sequencer slice.
package arc4_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned KEY_W  = 24;

    typedef enum logic [3:0] {
        IDLE,
        INIT_GO, INIT_ACK, INIT_RUN,
        KSA_GO,  KSA_ACK,  KSA_RUN,
        PRGA_GO, PRGA_ACK, PRGA_RUN
    } state_t;

    // Encoding doubles as the phase value shown on the LEDs.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        INIT = 2'd1,
        KSA  = 2'd2,
        PRGA = 2'd3
    } owner_t;

endpackage

// File: rtl/arc4_smux.sv
// S memory port mux: passes only the owning engine's request, all-zero when unowned.
module arc4_smux
    import arc4_pkg::*;
#(
    parameter int unsigned ADDR_W = arc4_pkg::ADDR_W,
    parameter int unsigned DATA_W = arc4_pkg::DATA_W
) (
    input  owner_t              owner,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [DATA_W-1:0]   init_wrdata,
    input  logic                init_wren,
    input  logic [ADDR_W-1:0]   ksa_addr,
    input  logic [DATA_W-1:0]   ksa_wrdata,
    input  logic                ksa_wren,
    input  logic [ADDR_W-1:0]   prga_addr,
    input  logic [DATA_W-1:0]   prga_wrdata,
    input  logic                prga_wren,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wrdata,
    output logic                s_wren
);

    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (owner)
            INIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            KSA: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            PRGA: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 engine sequencer (init -> ksa -> optional prga) with S memory arbitration.
// Define ARC4_SCHED_PRGA_EN to include the PRGA stage.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int unsigned ADDR_W = arc4_pkg::ADDR_W,
    parameter int unsigned DATA_W = arc4_pkg::DATA_W,
    parameter int unsigned KEY_W  = arc4_pkg::KEY_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [KEY_W-1:0]    key,
    output logic                rdy,
    output logic [1:0]          phase,
    output logic [KEY_W-1:0]    key_q,
    output logic                init_en,
    output logic                ksa_en,
    output logic                prga_en,
    input  logic                init_rdy,
    input  logic                ksa_rdy,
    input  logic                prga_rdy,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [DATA_W-1:0]   init_wrdata,
    input  logic                init_wren,
    input  logic [ADDR_W-1:0]   ksa_addr,
    input  logic [DATA_W-1:0]   ksa_wrdata,
    input  logic                ksa_wren,
    input  logic [ADDR_W-1:0]   prga_addr,
    input  logic [DATA_W-1:0]   prga_wrdata,
    input  logic                prga_wren,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wrdata,
    output logic                s_wren,
    input  logic [DATA_W-1:0]   s_rddata
);

    state_t state;
    owner_t owner;

    // Read data reaches the engines directly at the top level.
    logic [DATA_W-1:0] unused_s_rddata;
    assign unused_s_rddata = s_rddata;

`ifdef ARC4_SCHED_PRGA_EN
    logic prga_en_q;
    assign prga_en = prga_en_q;
`else
    logic unused_prga_rdy;
    assign unused_prga_rdy = prga_rdy;
    assign prga_en = 1'b0;
`endif

    assign phase = owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= NONE;
            rdy       <= 1'b1;
            key_q     <= '0;
            init_en   <= 1'b0;
            ksa_en    <= 1'b0;
`ifdef ARC4_SCHED_PRGA_EN
            prga_en_q <= 1'b0;
`endif
        end else begin
            init_en   <= 1'b0;
            ksa_en    <= 1'b0;
`ifdef ARC4_SCHED_PRGA_EN
            prga_en_q <= 1'b0;
`endif
            case (state)
                IDLE: if (en) begin
                    key_q <= key;
                    rdy   <= 1'b0;
                    owner <= INIT;
                    state <= INIT_GO;
                end
                INIT_GO: if (init_rdy) begin
                    init_en <= 1'b1;
                    state   <= INIT_ACK;
                end
                INIT_ACK: if (!init_rdy) state <= INIT_RUN;
                INIT_RUN: if (init_rdy) begin
                    owner <= KSA;
                    state <= KSA_GO;
                end
                KSA_GO: if (ksa_rdy) begin
                    ksa_en <= 1'b1;
                    state  <= KSA_ACK;
                end
                KSA_ACK: if (!ksa_rdy) state <= KSA_RUN;
                KSA_RUN: if (ksa_rdy) begin
`ifdef ARC4_SCHED_PRGA_EN
                    owner <= PRGA;
                    state <= PRGA_GO;
`else
                    owner <= NONE;
                    rdy   <= 1'b1;
                    state <= IDLE;
`endif
                end
`ifdef ARC4_SCHED_PRGA_EN
                PRGA_GO: if (prga_rdy) begin
                    prga_en_q <= 1'b1;
                    state     <= PRGA_ACK;
                end
                PRGA_ACK: if (!prga_rdy) state <= PRGA_RUN;
                PRGA_RUN: if (prga_rdy) begin
                    owner <= NONE;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
`endif
                default: begin
                    owner <= NONE;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    arc4_smux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_smux (
        .owner       (owner),
        .init_addr   (init_addr),
        .init_wrdata (init_wrdata),
        .init_wren   (init_wren),
        .ksa_addr    (ksa_addr),
        .ksa_wrdata  (ksa_wrdata),
        .ksa_wren    (ksa_wren),
        .prga_addr   (prga_addr),
        .prga_wrdata (prga_wrdata),
        .prga_wren   (prga_wren),
        .s_addr      (s_addr),
        .s_wrdata    (s_wrdata),
        .s_wren      (s_wren)
    );

endmodule
